banked_main_mem: RTL and testbench
==================================

Name: banked_main_mem

Overview:
- Four-bank, word-interleaved 16-bit main memory.
- Sits directly downstream of the direct-mapped cache controller and serves its line fills and write-backs.
- Accepts one read or write per cycle when the addressed bank is idle.
- Returns read data on a fixed 2-cycle pipeline, so a controller running issue -> wait -> capture sequences sees data in its capture cycle.
- Bank conflicts are signalled with a combinational stall.

Parameters:
- ROW_W, 13, row-index width per bank; row = addr[ROW_W+2:3], address bits above that are ignored.
- BANK_CYCLES, 4, cycles a bank stays busy after accepting an access (legal range 2..8).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  16  byte address; addr[2:1] selects the bank, addr[0] must be 0.
- data_in  input  16  write data.
- wr  input  1  write request.
- rd  input  1  read request.
- data_out  output  16  read data; valid only in the return cycle, 0 otherwise.
- stall  output  1  request not accepted this cycle; requester holds request and retries.
- busy  output  4  per-bank busy flags, bit i = bank i.
- err  output  1  one-cycle pulse flagging a rejected illegal request.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - data_out=0, err=0, busy=4'b0000, all bank counters 0, pipeline valid bits 0.
  - Any in-flight read is dropped.
  - Array contents are not reset.
- Request classes:
  - req = rd | wr.
  - illegal = (rd & wr) | (req & addr[0]).
  - bank b = addr[2:1].
- stall:
  - Combinational: stall = req & ~illegal & busy[b].
  - stall=0 when there is no request.
- Acceptance: at the rising edge ending cycle T, if req & ~illegal & ~busy[b]:
  - Load bank b's counter with BANK_CYCLES-1.
  - busy[b] = (counter != 0).
  - So bank b is busy in T+1..T+BANK_CYCLES-1 and free again at T+BANK_CYCLES.
  - Counters decrement by 1 per cycle and saturate at 0.
  - The four banks are independent.
- Write:
  - Array[b][row] <= data_in at the acceptance edge.
  - No response other than the busy effect.
- Read:
  - Array[b][row] is captured into a stage-1 register at the acceptance edge, with valid1=1.
  - data_out <= stage-1 data at the next edge.
  - data_out is valid for exactly cycle T+2, then returns to 0.
  - Back-to-back reads to different banks give consecutive data_out cycles T+2, T+3, ...
- Illegal request:
  - No array access, no busy update, stall=0.
  - err=1 during cycle T+1 only.
- Hazards: read-after-write to the same word in the same bank cannot overlap because the bank is busy. A read accepted at or after a write's acceptance edge returns the new data.
- Stalled request: no state changes except counter decrement. The requester is expected to hold addr, rd, wr and data_in stable until stall drops.
- The module has no internal request FSM. Its sequential state is the per-bank counters and the two-stage read pipeline (valid1/data1, data_out).

Optional Feature:
- Macro BANKED_MAIN_MEM_STATS_EN.
- Defined:
  - Adds output conflict_cnt[15:0]: increments in every cycle with stall=1 and saturates at 16'hFFFF.
  - Adds output access_cnt[15:0]: increments on every accepted access and saturates at 16'hFFFF.
  - Both counters are cleared by rst_n.
- Undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then write 16'hBEEF to addr 16'h0010, then read it:
  - Read accepted in cycle T.
  - data_out=16'hBEEF in cycle T+2 only; 0 in T+1 and T+3.
- Four writes, then four reads, to addrs 16'h0020, 0022, 0024, 0026 on consecutive cycles:
  - stall never asserted.
  - Read data returns on 4 consecutive cycles in order.
- Back-to-back reads to 16'h0040 and 16'h0048 (same bank 0):
  - Second read stalls in cycles T+1..T+3 and is accepted in T+4.
  - Its data appears in T+6.
- rd=wr=1 at 16'h0002:
  - stall=0, err=1 in the next cycle only.
  - Array unchanged: a later read of 16'h0002 returns its prior value.
- Read to 16'h0003:
  - err pulse, data_out stays 0, busy stays 0.
- Read accepted, then rst_n low for 1 cycle before the return:
  - data_out stays 0, busy=0 immediately.
  - With BANKED_MAIN_MEM_STATS_EN defined, counters are 0 after reset.
  - In the 3rd scenario conflict_cnt=3 and access_cnt=2.

Source files
------------

// File: rtl/banked_main_mem.sv
// Four-bank, word-interleaved 16-bit main memory with a fixed 2-cycle read return.
// Define BANKED_MAIN_MEM_STATS_EN to add the conflict_cnt/access_cnt statistics outputs.
module banked_main_mem #(
    parameter int ROW_W       = 13,
    parameter int BANK_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        stall,
    output logic [3:0]  busy,
    output logic        err
`ifdef BANKED_MAIN_MEM_STATS_EN
    ,
    output logic [15:0] conflict_cnt,
    output logic [15:0] access_cnt
`endif
);
    localparam int DATA_W = 16;
    localparam int CNT_W  = 3;
    localparam int DEPTH  = 4 * (2 ** ROW_W);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_CYCLES - 1);

    logic              req;
    logic              illegal;
    logic              accept;
    logic [1:0]        bank;
    logic [ROW_W+1:0]  mem_idx;
    logic [CNT_W-1:0]  cnt_q [4];
    logic [CNT_W-1:0]  cnt_d [4];
    logic              vld_p1_q, vld_p1_d;
    logic [DATA_W-1:0] data_p1_q;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] mem [DEPTH];

    assign req     = rd | wr;
    assign illegal = (rd & wr) | (req & addr[0]);
    assign bank    = addr[2:1];
    assign mem_idx = {addr[ROW_W+2:3], bank};

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            busy[b] = (cnt_q[b] != '0);
        end
    end

    assign stall  = req & ~illegal & busy[bank];
    assign accept = req & ~illegal & ~busy[bank];

    // Bank occupancy: reload on acceptance, otherwise count down to zero.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            cnt_d[b] = cnt_q[b];
            if (accept && (bank == 2'(b))) begin
                cnt_d[b] = CNT_LOAD;
            end else if (cnt_q[b] != '0) begin
                cnt_d[b] = cnt_q[b] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        vld_p1_d   = accept & rd;
        data_out_d = vld_p1_q ? data_p1_q : '0;
        err_d      = illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= '0;
            end
            vld_p1_q   <= 1'b0;
            data_out_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                cnt_q[b] <= cnt_d[b];
            end
            vld_p1_q   <= vld_p1_d;
            data_out_q <= data_out_d;
            err_q      <= err_d;
        end
    end

    // Stage p1: array access at the acceptance edge; array and data stage carry no reset.
    always_ff @(posedge clk) begin
        if (accept & wr) begin
            mem[mem_idx] <= data_in;
        end
        if (accept & rd) begin
            data_p1_q <= mem[mem_idx];
        end
    end

    assign data_out = data_out_q;
    assign err      = err_q;

`ifdef BANKED_MAIN_MEM_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;
    logic [15:0] access_cnt_q, access_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        access_cnt_d   = access_cnt_q;
        if (stall && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
        if (accept && (access_cnt_q != 16'hFFFF)) begin
            access_cnt_d = access_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
            access_cnt_q   <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
            access_cnt_q   <= access_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
    assign access_cnt   = access_cnt_q;
`endif

endmodule

// File: tb/tb_banked_main_mem.sv
// Self-checking bench for banked_main_mem: directed scenarios plus randomized traffic
// against a cycle-indexed behavioural model (bank free times, word array, return schedule).
module tb_banked_main_mem;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] data_in = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;
`ifdef BANKED_MAIN_MEM_STATS_EN
    logic [15:0] conflict_cnt;
    logic [15:0] access_cnt;
`endif

    localparam int BC = 4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int free_at [4];
    logic [15:0] mem_m [32768];
    bit          known [32768];
    logic [15:0] exp_rd [int];
    bit          exp_known [int];
    bit          err_due [int];
    int          conf_m = 0;
    int          acc_m = 0;
    logic        last_stall;

    banked_main_mem dut (
        .clk(clk),
        .rst_n(rst_n),
        .addr(addr),
        .data_in(data_in),
        .wr(wr),
        .rd(rd),
        .data_out(data_out),
        .stall(stall),
        .busy(busy),
        .err(err)
`ifdef BANKED_MAIN_MEM_STATS_EN
        ,
        .conflict_cnt(conflict_cnt),
        .access_cnt(access_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic check_outputs();
        logic [3:0] eb;
        for (int b = 0; b < 4; b++) eb[b] = (cyc < free_at[b]);
        chk("busy", busy, eb);
        chk("err", err, err_due.exists(cyc));
        if (exp_rd.exists(cyc)) begin
            if (exp_known[cyc]) chk("data_out", data_out, exp_rd[cyc]);
        end else begin
            chk("data_out_idle", data_out, 16'h0);
        end
`ifdef BANKED_MAIN_MEM_STATS_EN
        chk("conflict_cnt", conflict_cnt, conf_m);
        chk("access_cnt", access_cnt, acc_m);
`endif
    endtask

    // One cycle: check stall for the current inputs, update the model, cross the edge, check outputs.
    task automatic tick();
        bit rq, il, es, acc;
        int b, idx;
        #1;
        rq  = rd | wr;
        il  = (rd & wr) | (rq & addr[0]);
        b   = int'(addr[2:1]);
        idx = int'(addr[15:1]);
        es  = rq && !il && (cyc < free_at[b]);
        chk("stall", stall, es);
        last_stall = stall;
        acc = rq && !il && !es;
        if (acc) begin
            free_at[b] = cyc + BC;
            if (acc_m < 65535) acc_m++;
            if (wr) begin
                mem_m[idx] = data_in;
                known[idx] = 1'b1;
            end else begin
                exp_rd[cyc + 2]    = mem_m[idx];
                exp_known[cyc + 2] = known[idx];
            end
        end
        if (il) err_due[cyc + 1] = 1'b1;
        if (es && conf_m < 65535) conf_m++;
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(input int k);
        rd = 1'b0;
        wr = 1'b0;
        repeat (k) tick();
    endtask

    // Present a request and hold it until accepted; returns the number of stalled cycles.
    task automatic req(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d,
                       output int nst);
        rd = r; wr = w; addr = a; data_in = d;
        nst = 0;
        tick();
        while (last_stall && nst < 16) begin
            nst++;
            tick();
        end
        if (last_stall) begin
            checks++;
            errors++;
            $display("FAIL req_timeout at cycle %0d: addr %h still stalled after %0d cycles", cyc, a, nst);
        end
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic do_reset();
        rd = 1'b0;
        wr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_data_out", data_out, 16'h0);
        chk("rst_busy", busy, 4'h0);
        chk("rst_err", err, 1'b0);
`ifdef BANKED_MAIN_MEM_STATS_EN
        chk("rst_conflict_cnt", conflict_cnt, 16'h0);
        chk("rst_access_cnt", access_cnt, 16'h0);
`endif
        for (int b = 0; b < 4; b++) free_at[b] = 0;
        exp_rd.delete();
        exp_known.delete();
        err_due.delete();
        conf_m = 0;
        acc_m = 0;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    task automatic run_random(input int iters);
        int k, n;
        logic [15:0] a, d;
        for (int it = 0; it < iters; it++) begin
            k = $urandom_range(0, 19);
            a = 16'($urandom_range(0, 31) * 2);
            if ($urandom_range(0, 7) == 0) a = 16'($urandom) & 16'hFFFE;
            d = 16'($urandom);
            if (k == 0)       req(1'b1, 1'b1, a, d, n);
            else if (k == 1)  req(1'b1, 1'b0, a | 16'h1, d, n);
            else if (k <= 8)  req(1'b0, 1'b1, a, d, n);
            else if (k <= 15) req(1'b1, 1'b0, a, d, n);
            else              idle(1);
        end
    endtask

    initial begin
        int n, tot;
        logic [15:0] got [6];
        for (int b = 0; b < 4; b++) free_at[b] = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Write then read back a single word.
        req(1'b0, 1'b1, 16'h0010, 16'hBEEF, n);
        idle(4);
        req(1'b1, 1'b0, 16'h0010, 16'h0000, n);
        chk("s1_t1", data_out, 16'h0);
        tick();
        chk("s1_t2", data_out, 16'hBEEF);
        tick();
        chk("s1_t3", data_out, 16'h0);
        idle(4);

        // Four banks in a row: no stalls, four consecutive returns.
        tot = 0;
        for (int i = 0; i < 4; i++) begin
            req(1'b0, 1'b1, 16'h0020 + 16'(2 * i), 16'hA000 + 16'(i), n);
            tot += n;
        end
        for (int i = 0; i < 4; i++) begin
            req(1'b1, 1'b0, 16'h0020 + 16'(2 * i), 16'h0000, n);
            tot += n;
            got[i] = data_out;
        end
        tick(); got[4] = data_out;
        tick(); got[5] = data_out;
        chk("s2_stalls", tot, 0);
        chk("s2_ret0", got[0], 16'h0);
        chk("s2_ret1", got[1], 16'hA000);
        chk("s2_ret2", got[2], 16'hA001);
        chk("s2_ret3", got[3], 16'hA002);
        chk("s2_ret4", got[4], 16'hA003);
        chk("s2_ret5", got[5], 16'h0);
        idle(4);

        // Same-bank back-to-back reads; array survives reset.
        req(1'b0, 1'b1, 16'h0040, 16'h1111, n);
        req(1'b0, 1'b1, 16'h0048, 16'h2222, n);
        idle(6);
        do_reset();
        req(1'b1, 1'b0, 16'h0040, 16'h0000, n);
        chk("s3_first_stalls", n, 0);
        req(1'b1, 1'b0, 16'h0048, 16'h0000, n);
        chk("s3_second_stalls", n, 3);
        tick();
        chk("s3_data", data_out, 16'h2222);
`ifdef BANKED_MAIN_MEM_STATS_EN
        chk("s3_conflict_cnt", conflict_cnt, 16'd3);
        chk("s3_access_cnt", access_cnt, 16'd2);
`endif
        idle(6);

        // rd & wr together is rejected and leaves the array alone.
        req(1'b0, 1'b1, 16'h0002, 16'h5A5A, n);
        idle(4);
        req(1'b1, 1'b1, 16'h0002, 16'hFFFF, n);
        chk("s4_err", err, 1'b1);
        chk("s4_busy", busy, 4'h0);
        tick();
        chk("s4_err_clear", err, 1'b0);
        idle(2);
        req(1'b1, 1'b0, 16'h0002, 16'h0000, n);
        tick();
        chk("s4_prior", data_out, 16'h5A5A);
        idle(2);

        // Odd address read.
        req(1'b1, 1'b0, 16'h0003, 16'h0000, n);
        chk("s5_err", err, 1'b1);
        chk("s5_busy", busy, 4'h0);
        chk("s5_data", data_out, 16'h0);
        tick();
        chk("s5_err_clear", err, 1'b0);
        chk("s5_data2", data_out, 16'h0);
        idle(4);

        // Reset while a read is in flight.
        req(1'b1, 1'b0, 16'h0010, 16'h0000, n);
        do_reset();
        idle(3);

        run_random(400);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
